// File: rtl/control_unit.sv
// Multi-cycle control FSM: decodes the IR opcode into datapath strobes, one state per cycle.
// Keeps a sticky illegal-opcode flag and a wrapping count of retired instructions.
module control_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instruction_in,
   input  logic        alu_zero,
   output logic        PCWrite,
   output logic [1:0]  PCSource,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ALUOp,
   output logic        LoadAOut,
   output logic        LoadRegA,
   output logic        LoadRegB,
   output logic        LoadMDR,
   output logic        IRWrite,
   output logic        RegWrite,
   output logic        MemToReg,
   output logic        DMemRead,
   output logic        DMemWrite,
   output logic        IMemRead,
   output logic [3:0]  state_out,
   output logic        illegal,
   output logic [31:0] retired
);

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAddr  = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StExecR    = 4'd6,
      StExecI    = 4'd7,
      StAluWb    = 4'd8,
      StBranch   = 4'd9,
      StIllegal  = 4'd10
   } state_e;

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpRtype  = 7'b0110011;
   localparam logic [6:0] OpItype  = 7'b0010011;
   localparam logic [6:0] OpBranch = 7'b1100011;

   typedef struct packed {
      logic       pc_write;
      logic [1:0] pc_source;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       load_aout;
      logic       load_rega;
      logic       load_regb;
      logic       load_mdr;
      logic       ir_write;
      logic       reg_write;
      logic       mem_to_reg;
      logic       dmem_read;
      logic       dmem_write;
      logic       imem_read;
   } ctrl_t;

   state_e      state_q, state_d;
   ctrl_t       ctrl;
   logic        retire;
   logic        illegal_q;
   logic [31:0] retired_q;
   logic [6:0]  opcode;
   logic        unused_instr;

   assign opcode       = instruction_in[6:0];
   assign unused_instr = ^instruction_in[31:7];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StFetch;
         illegal_q <= 1'b0;
         retired_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_q | (state_d == StIllegal);
         if (retire) begin
            retired_q <= retired_q + 32'd1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ctrl    = '0;
      retire  = 1'b0;
      unique case (state_q)
         StFetch: begin
            ctrl.imem_read = 1'b1;
            ctrl.ir_write  = 1'b1;
            ctrl.load_aout = 1'b1;
            ctrl.alu_src_b = 2'd1;
            state_d        = StDecode;
         end
         StDecode: begin
            // PC <= PC+4 (held in ALUOut) while ALUOut <= branch target on the same edge.
            ctrl.load_rega = 1'b1;
            ctrl.load_regb = 1'b1;
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = 2'd1;
            ctrl.load_aout = 1'b1;
            ctrl.alu_src_b = 2'd3;
            case (opcode)
               OpLoad, OpStore: state_d = StMemAddr;
               OpRtype:         state_d = StExecR;
               OpItype:         state_d = StExecI;
               OpBranch:        state_d = StBranch;
               default:         state_d = StIllegal;
            endcase
         end
         StMemAddr: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 2'd2;
            ctrl.load_aout = 1'b1;
            state_d        = (opcode == OpStore) ? StMemWrite : StMemRead;
         end
         StMemRead: begin
            ctrl.dmem_read = 1'b1;
            ctrl.load_mdr  = 1'b1;
            state_d        = StMemWb;
         end
         StMemWb: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            retire          = 1'b1;
            state_d         = StFetch;
         end
         StMemWrite: begin
            ctrl.dmem_write = 1'b1;
            retire          = 1'b1;
            state_d         = StFetch;
         end
         StExecR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = 2'b10;
            ctrl.load_aout = 1'b1;
            state_d        = StAluWb;
         end
         StExecI: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 2'd2;
            ctrl.load_aout = 1'b1;
            state_d        = StAluWb;
         end
         StAluWb: begin
            ctrl.reg_write = 1'b1;
            retire         = 1'b1;
            state_d        = StFetch;
         end
         StBranch: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = 2'b01;
            ctrl.pc_source = 2'd1;
            ctrl.pc_write  = alu_zero;
            retire         = 1'b1;
            state_d        = StFetch;
         end
         StIllegal: begin
            state_d = StIllegal;
         end
         default: begin
            state_d = StFetch;
         end
      endcase
      // Reset masks every strobe so an interrupted instruction issues no partial writes.
      if (reset) begin
         ctrl = '0;
      end
   end

   assign PCWrite   = ctrl.pc_write;
   assign PCSource  = ctrl.pc_source;
   assign ALUSrcA   = ctrl.alu_src_a;
   assign ALUSrcB   = ctrl.alu_src_b;
   assign ALUOp     = ctrl.alu_op;
   assign LoadAOut  = ctrl.load_aout;
   assign LoadRegA  = ctrl.load_rega;
   assign LoadRegB  = ctrl.load_regb;
   assign LoadMDR   = ctrl.load_mdr;
   assign IRWrite   = ctrl.ir_write;
   assign RegWrite  = ctrl.reg_write;
   assign MemToReg  = ctrl.mem_to_reg;
   assign DMemRead  = ctrl.dmem_read;
   assign DMemWrite = ctrl.dmem_write;
   assign IMemRead  = ctrl.imem_read;
   assign state_out = state_q;
   assign illegal   = illegal_q;
   assign retired   = retired_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: each driven cycle queues its expected state/strobes,
// a negedge monitor pops and compares.
module tb_control_unit;

   logic        clk;
   logic        reset;
   logic [31:0] instruction_in;
   logic        alu_zero;
   logic        PCWrite;
   logic [1:0]  PCSource;
   logic        ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic [1:0]  ALUOp;
   logic        LoadAOut, LoadRegA, LoadRegB, LoadMDR, IRWrite;
   logic        RegWrite, MemToReg, DMemRead, DMemWrite, IMemRead;
   logic [3:0]  state_out;
   logic        illegal;
   logic [31:0] retired;

   control_unit dut (
      .clk            (clk),
      .reset          (reset),
      .instruction_in (instruction_in),
      .alu_zero       (alu_zero),
      .PCWrite        (PCWrite),
      .PCSource       (PCSource),
      .ALUSrcA        (ALUSrcA),
      .ALUSrcB        (ALUSrcB),
      .ALUOp          (ALUOp),
      .LoadAOut       (LoadAOut),
      .LoadRegA       (LoadRegA),
      .LoadRegB       (LoadRegB),
      .LoadMDR        (LoadMDR),
      .IRWrite        (IRWrite),
      .RegWrite       (RegWrite),
      .MemToReg       (MemToReg),
      .DMemRead       (DMemRead),
      .DMemWrite      (DMemWrite),
      .IMemRead       (IMemRead),
      .state_out      (state_out),
      .illegal        (illegal),
      .retired        (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [31:0] JUNK = 32'hFFFF_FFFF;  // opcode 7F: must be ignored outside DECODE/MEM_ADDR
   localparam logic [31:0] RTY  = 32'h00B5_0533;
   localparam logic [31:0] ITY  = 32'h0015_0513;
   localparam logic [31:0] LDW  = 32'h0005_2503;
   localparam logic [31:0] STW  = 32'h00A5_2023;
   localparam logic [31:0] BEQ  = 32'h0000_0063;
   localparam logic [31:0] BAD  = 32'h0000_007F;

   typedef struct {
      logic [3:0]  st;
      logic [17:0] ctrl;
      logic [31:0] ret;
      logic        ill;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Strobe word: {PCWrite, PCSource, ALUSrcA, ALUSrcB, ALUOp,
   //               LoadAOut LoadRegA LoadRegB LoadMDR IRWrite, RegWrite MemToReg DMemRead DMemWrite IMemRead}
   function automatic logic [17:0] exp_ctrl(input logic [3:0] st, input logic z);
      case (st)
         4'd0:    return {1'b0, 2'd0, 1'b0, 2'd1, 2'd0, 5'b10001, 5'b00001};
         4'd1:    return {1'b1, 2'd1, 1'b0, 2'd3, 2'd0, 5'b11100, 5'b00000};
         4'd2:    return {1'b0, 2'd0, 1'b1, 2'd2, 2'd0, 5'b10000, 5'b00000};
         4'd3:    return {1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 5'b00010, 5'b00100};
         4'd4:    return {1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 5'b00000, 5'b11000};
         4'd5:    return {1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 5'b00000, 5'b00010};
         4'd6:    return {1'b0, 2'd0, 1'b1, 2'd0, 2'd2, 5'b10000, 5'b00000};
         4'd7:    return {1'b0, 2'd0, 1'b1, 2'd2, 2'd0, 5'b10000, 5'b00000};
         4'd8:    return {1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 5'b00000, 5'b10000};
         4'd9:    return {z,    2'd1, 1'b1, 2'd0, 2'd1, 5'b00000, 5'b00000};
         default: return 18'd0;
      endcase
   endfunction

   task automatic check(input string nm, input string what, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s %s: got 0x%08h, expected 0x%08h", nm, what, act, exp);
      end
   endtask

   // Drive one cycle's inputs and queue what the DUT must show during that cycle.
   task automatic cyc(input logic [31:0] ins, input logic z, input logic r, input logic [3:0] st,
                      input logic [31:0] ret, input logic ill, input string tag);
      exp_t e;
      reset          = r;
      instruction_in = ins;
      alu_zero       = z;
      e.st   = st;
      e.ctrl = r ? 18'd0 : exp_ctrl(st, z);
      e.ret  = ret;
      e.ill  = ill;
      e.tag  = tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (sb.size() != 0) begin
         exp_t e;
         logic [17:0] got;
         e   = sb.pop_front();
         got = {PCWrite, PCSource, ALUSrcA, ALUSrcB, ALUOp, LoadAOut, LoadRegA, LoadRegB,
                LoadMDR, IRWrite, RegWrite, MemToReg, DMemRead, DMemWrite, IMemRead};
         check(e.tag, "state", {28'd0, state_out}, {28'd0, e.st});
         check(e.tag, "ctrl", {14'd0, got}, {14'd0, e.ctrl});
         check(e.tag, "retired", retired, e.ret);
         check(e.tag, "illegal", {31'd0, illegal}, {31'd0, e.ill});
      end
   end

   initial begin
      reset          = 1'b1;
      instruction_in = 32'd0;
      alu_zero       = 1'b0;
      @(posedge clk);
      #1;
      cyc(JUNK, 1'b1, 1'b1, 4'd0, 32'd0, 1'b0, "reset");

      // R-type: 0,1,6,8
      cyc(JUNK, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, "r_fetch");
      cyc(RTY,  1'b0, 1'b0, 4'd1, 32'd0, 1'b0, "r_decode");
      cyc(JUNK, 1'b1, 1'b0, 4'd6, 32'd0, 1'b0, "r_exec");
      cyc(JUNK, 1'b1, 1'b0, 4'd8, 32'd0, 1'b0, "r_wb");
      // I-type: 0,1,7,8
      cyc(JUNK, 1'b0, 1'b0, 4'd0, 32'd1, 1'b0, "i_fetch");
      cyc(ITY,  1'b0, 1'b0, 4'd1, 32'd1, 1'b0, "i_decode");
      cyc(JUNK, 1'b0, 1'b0, 4'd7, 32'd1, 1'b0, "i_exec");
      cyc(JUNK, 1'b0, 1'b0, 4'd8, 32'd1, 1'b0, "i_wb");
      // Load: 0,1,2,3,4
      cyc(JUNK, 1'b0, 1'b0, 4'd0, 32'd2, 1'b0, "ld_fetch");
      cyc(LDW,  1'b0, 1'b0, 4'd1, 32'd2, 1'b0, "ld_decode");
      cyc(LDW,  1'b0, 1'b0, 4'd2, 32'd2, 1'b0, "ld_addr");
      cyc(JUNK, 1'b0, 1'b0, 4'd3, 32'd2, 1'b0, "ld_read");
      cyc(JUNK, 1'b0, 1'b0, 4'd4, 32'd2, 1'b0, "ld_wb");
      // Store: 0,1,2,5
      cyc(JUNK, 1'b0, 1'b0, 4'd0, 32'd3, 1'b0, "st_fetch");
      cyc(STW,  1'b0, 1'b0, 4'd1, 32'd3, 1'b0, "st_decode");
      cyc(STW,  1'b0, 1'b0, 4'd2, 32'd3, 1'b0, "st_addr");
      cyc(JUNK, 1'b0, 1'b0, 4'd5, 32'd3, 1'b0, "st_write");
      // Branch taken, then not taken
      cyc(JUNK, 1'b0, 1'b0, 4'd0, 32'd4, 1'b0, "bt_fetch");
      cyc(BEQ,  1'b0, 1'b0, 4'd1, 32'd4, 1'b0, "bt_decode");
      cyc(JUNK, 1'b1, 1'b0, 4'd9, 32'd4, 1'b0, "bt_branch");
      cyc(JUNK, 1'b0, 1'b0, 4'd0, 32'd5, 1'b0, "bn_fetch");
      cyc(BEQ,  1'b1, 1'b0, 4'd1, 32'd5, 1'b0, "bn_decode");
      cyc(JUNK, 1'b0, 1'b0, 4'd9, 32'd5, 1'b0, "bn_branch");
      // Illegal opcode: lock in state 10, legal opcodes offered meanwhile must not escape
      cyc(JUNK, 1'b0, 1'b0, 4'd0, 32'd6, 1'b0, "ill_fetch");
      cyc(BAD,  1'b0, 1'b0, 4'd1, 32'd6, 1'b0, "ill_decode");
      for (int i = 0; i < 20; i++) begin
         cyc(RTY, 1'b1, 1'b0, 4'd10, 32'd6, 1'b1, "ill_hold");
      end
      cyc(RTY,  1'b1, 1'b1, 4'd10, 32'd6, 1'b1, "ill_reset");
      // Reset during MEM_READ: strobes dropped that cycle, FETCH next
      cyc(JUNK, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, "rr_fetch");
      cyc(LDW,  1'b0, 1'b0, 4'd1, 32'd0, 1'b0, "rr_decode");
      cyc(LDW,  1'b0, 1'b0, 4'd2, 32'd0, 1'b0, "rr_addr");
      cyc(JUNK, 1'b0, 1'b1, 4'd3, 32'd0, 1'b0, "rr_read_reset");
      // Counter wrap: preload all-ones, retire one R-type
      force dut.retired_q = 32'hFFFF_FFFF;
      #1;
      release dut.retired_q;
      cyc(JUNK, 1'b0, 1'b0, 4'd0, 32'hFFFF_FFFF, 1'b0, "wrap_fetch");
      cyc(RTY,  1'b0, 1'b0, 4'd1, 32'hFFFF_FFFF, 1'b0, "wrap_decode");
      cyc(JUNK, 1'b0, 1'b0, 4'd6, 32'hFFFF_FFFF, 1'b0, "wrap_exec");
      cyc(JUNK, 1'b0, 1'b0, 4'd8, 32'hFFFF_FFFF, 1'b0, "wrap_wb");
      cyc(JUNK, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, "wrap_done");

      @(negedge clk);
      #1;
      check("drain", "pending", sb.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset, with ports as listed.
REQ-002 clk  in  1  rising-edge clock, sole clock.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 instruction_in  in  32  current IR contents from the datapath; opcode = [6:0].
REQ-005 alu_zero  in  1  datapath ALU zero flag.
REQ-006 PCWrite  out  1  load PC.
REQ-007 PCSource  out  2  PC mux select: 0 = ALU result, 1 = ALUOut register.
REQ-008 ALUSrcA  out  1  0 = PC, 1 = register A.
REQ-009 ALUSrcB  out  2  0 = register B, 1 = constant 4, 2 = imm, 3 = imm*2.
REQ-010 ALUOp  out  2  00 = add, 01 = sub, 10 = funct-decoded.
REQ-011 LoadAOut, LoadRegA, LoadRegB, LoadMDR, IRWrite  out  1 each  register load enables.
REQ-012 RegWrite  out  1  register-file write.
REQ-013 MemToReg  out  1  writeback select: 0 = ALUOut, 1 = MDR.
REQ-014 DMemRead, DMemWrite, IMemRead  out  1 each  memory strobes.
REQ-015 state_out  out  4  current state encoding, for debug.
REQ-016 illegal  out  1  sticky; set on an unknown opcode.
REQ-017 retired  out  32  count of completed instructions.

Function
REQ-018 SHALL implement a registered FSM with these 4-bit encodings:
- FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4, MEM_WRITE = 5
- EXEC_R = 6, EXEC_I = 7, ALU_WB = 8, BRANCH = 9, ILLEGAL = 10
REQ-019 Outputs SHALL be decoded from state only; the single exception is PCWrite in BRANCH, which equals alu_zero. Any output not listed for a state SHALL be 0.
REQ-020 FETCH SHALL assert IMemRead, IRWrite and LoadAOut with ALUSrcA=0, ALUSrcB=1, ALUOp=00 (ALUOut <= PC+4), then go to DECODE.
REQ-021 DECODE SHALL assert the following, so that on the same edge PC <= PC+4 and ALUOut <= branch target:
- LoadRegA, LoadRegB, PCWrite with PCSource=1
- LoadAOut with ALUSrcA=0, ALUSrcB=3, ALUOp=00
REQ-022 DECODE SHALL branch on opcode:
- 0000011 or 0100011 -> MEM_ADDR
- 0110011 -> EXEC_R
- 0010011 -> EXEC_I
- 1100011 -> BRANCH
- any other opcode -> ILLEGAL
REQ-023 MEM_ADDR SHALL assert ALUSrcA=1, ALUSrcB=2, ALUOp=00 and LoadAOut; next state is MEM_READ for a load, MEM_WRITE for a store.
REQ-024 MEM_READ SHALL assert DMemRead and LoadMDR, then go to MEM_WB.
REQ-025 MEM_WB SHALL assert RegWrite with MemToReg=1, then go to FETCH.
REQ-026 MEM_WRITE SHALL assert DMemWrite, then go to FETCH.
REQ-027 EXEC_R SHALL assert ALUSrcA=1, ALUSrcB=0, ALUOp=10 and LoadAOut, then go to ALU_WB.
REQ-028 EXEC_I SHALL assert ALUSrcA=1, ALUSrcB=2, ALUOp=00 and LoadAOut, then go to ALU_WB.
REQ-029 ALU_WB SHALL assert RegWrite with MemToReg=0, then go to FETCH.
REQ-030 BRANCH SHALL assert ALUSrcA=1, ALUSrcB=0, ALUOp=01 and PCSource=1, with PCWrite=alu_zero, then go to FETCH.
REQ-031 ILLEGAL SHALL drive every control output to 0, set illegal=1, and remain in ILLEGAL until reset.
REQ-032 Latency in cycles, counted from FETCH: load 5, store 4, R-type 4, I-type 4, branch 3.
REQ-033 retired SHALL increment by 1 on the final cycle of each instruction (MEM_WB, MEM_WRITE, ALU_WB, BRANCH) and wrap from 0xFFFFFFFF to 0.
REQ-034 retired SHALL NOT increment in ILLEGAL, and SHALL NOT increment on a cycle where reset is high.
REQ-035 instruction_in SHALL be sampled only in DECODE and MEM_ADDR; its value in other states SHALL have no effect.

Reset
REQ-036 While reset is high, all control outputs SHALL be 0 combinationally; at the next rising edge state SHALL become FETCH, and illegal and retired SHALL become 0.
REQ-037 A reset asserted in any state, including mid-instruction and ILLEGAL, SHALL take priority; the next state SHALL be FETCH and no partial writes SHALL be issued on the reset cycle.

Verification
REQ-038 Reset, release, opcode 0110011: state_out = 0,1,6,8,0; RegWrite=1 only in state 8; retired 0 -> 1.
REQ-039 Load (0000011): states 0,1,2,3,4; DMemRead and LoadMDR in state 3; MemToReg=1 and RegWrite=1 in state 4; store (0100011): states 0,1,2,5 with DMemWrite only in state 5.
REQ-040 Branch (1100011) with alu_zero=1 in BRANCH -> PCWrite=1 and PCSource=1; repeat with alu_zero=0 -> PCWrite=0; retired increments in both cases.
REQ-041 Opcode 1111111 -> state 10, illegal=1, all controls 0 held for 20 cycles; retired unchanged; reset -> state 0, illegal=0.
REQ-042 Reset asserted in MEM_READ -> DMemRead=0 on that cycle, state 0 next cycle; preload retired near 0xFFFFFFFF, complete one instruction -> retired = 0.
